updn_sweep_ctrl: RTL
====================

# updn_sweep_ctrl

Sequencing controller for the team's width-parameterised up/down counter. On a start request it loads a start value into the counter, then drives it in repeated up-then-down sweeps between its terminal counts. It holds the counter for exactly one cycle at each terminal so the count never wraps. It sits between a host or scheduler issuing start/abort and the counter's data/load/cen/up_dn pins, and reports busy, completion and sweep progress.

## Interface
- `width`, 4, counter width; must match the attached counter.
- `sweeps_w`, 4, width of sweep-count request and progress.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: start request, sampled only in IDLE.
- `start_val` in width: counter start value, latched on start accept.
- `sweeps` in sweeps_w: number of full up+down sweeps, latched on start accept.
- `abort` in 1: synchronous abort, honoured in any busy state.
- `count_in` in width: counter's `count` output.
- `tercnt_in` in 1: counter's `tercnt` output. It is high when count is all-ones with up_dn=1, or zero with up_dn=0. It is independent of cen.
- `ctr_data` out width: to counter `data`; holds the latched start_val.
- `ctr_load` out 1: to counter `load`, active-low synchronous load.
- `ctr_cen` out 1: to counter `cen`.
- `ctr_up_dn` out 1: to counter `up_dn`; 1 = up.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle completion pulse.
- `sweep_cnt` out sweeps_w: completed sweeps in the current or last sequence.

## Operation
- The FSM has five states: IDLE, LOAD, UP, DOWN, DONE.
- IDLE: ctr_load=1, ctr_cen=0, ctr_up_dn=1, busy=0.
  - start=1 with sweeps≠0: latch start_val→ctr_data and sweeps→remaining, clear sweep_cnt, go to LOAD.
  - start=1 with sweeps=0: clear sweep_cnt, go to DONE; the counter is untouched.
- LOAD, one cycle: ctr_load=0, ctr_cen=0, ctr_up_dn=1, busy=1. Then go to UP.
- UP: ctr_load=1, ctr_up_dn=1, ctr_cen=~tercnt_in, busy=1. When tercnt_in=1, go to DOWN. The count holds at all-ones for that cycle.
- DOWN: ctr_load=1, ctr_up_dn=0, ctr_cen=~tercnt_in, busy=1. When tercnt_in=1 (count=0):
  - increment sweep_cnt and decrement remaining;
  - if remaining was 1, go to DONE; otherwise go to UP.
- DONE, one cycle: done=1, busy=0, counter idle outputs as in IDLE. Then go to IDLE.
- abort=1 in LOAD/UP/DOWN: go to IDLE at the next edge. No done pulse. The count freezes where it stands. sweep_cnt keeps its value.
- abort has priority over the tercnt transition in the same cycle.
- start outside IDLE is ignored. abort in IDLE or DONE is ignored.
- Output logic:
  - ctr_cen is combinational from state and tercnt_in.
  - ctr_load, ctr_up_dn and busy are decoded from the state register only.
  - ctr_data, sweep_cnt and remaining are registers.
- count_in is for status and debug only; the FSM does not use it for decisions.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, ctr_data=0, ctr_load=1, ctr_cen=0, ctr_up_dn=1, busy=0, done=0, sweep_cnt=0.
- A reset mid-sequence aborts immediately and produces no done pulse.
- Let M=2^width−1 and s=start_val, with edge E0 accepting start.
  - LOAD occupies E0–E1; the counter loads s at E1.
  - UP lasts M−s+1 cycles: M−s increments plus one hold.
  - Each DOWN lasts M+1 cycles. Each subsequent UP lasts M+1 cycles.
- Busy length = 1 + (M−s+1) + (M+1) + (N−1)·2(M+1) cycles.
- done is high in the cycle after the last busy cycle.
- The count never transitions M→0 or 0→M.
- The sweep_cnt increment is visible the cycle after the DOWN terminal edge.

## Test plan
- width=4, start_val=7, sweeps=1, start pulse → ctr_load=0 for 1 cycle. Count runs 7..15, holds 15 one cycle, then runs 15..0. busy high 26 cycles; done pulse 26 edges after accept; sweep_cnt=1.
- sweeps=3, start_val=0 → busy = 1+16+16+4·16 = 97 cycles. sweep_cnt steps 1, 2, 3; exactly one done pulse.
- start_val=15, sweeps=1 → UP lasts 1 cycle with ctr_cen=0. No 15→0 wrap; busy 18 cycles.
- sweeps=0 → done pulse the cycle after accept, busy never high, ctr_load never low, sweep_cnt=0.
- abort mid-DOWN at count=9 → next cycle ctr_cen=0, busy=0, and the count stays 9. No done pulse; start during busy ignored.
- rst asserted mid-UP → all outputs at reset values immediately, asynchronously. A new start after release runs a full sequence.

Source files
------------

// File: rtl/updn_sweep_ctrl.sv
// Sweep sequencer for the up/down counter: load, then up/down sweeps
// between terminal counts, holding one cycle at each terminal.
module updn_sweep_ctrl #(
   parameter int width    = 4,
   parameter int sweeps_w = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [width-1:0]    start_val,
   input  logic [sweeps_w-1:0] sweeps,
   input  logic                abort,
   input  logic [width-1:0]    count_in,
   input  logic                tercnt_in,
   output logic [width-1:0]    ctr_data,
   output logic                ctr_load,
   output logic                ctr_cen,
   output logic                ctr_up_dn,
   output logic                busy,
   output logic                done,
   output logic [sweeps_w-1:0] sweep_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_UP,
      S_DOWN,
      S_DONE
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [width-1:0]     r_data;
   logic [sweeps_w-1:0]  r_rem;
   logic [sweeps_w-1:0]  r_sweep_cnt;
   logic                 w_accept;
   logic                 w_sweep_end;
   logic                 w_unused;

   // count_in is observed by the host only
   assign w_unused = ^count_in;

   always_comb begin
      w_next      = r_state;
      w_accept    = 1'b0;
      w_sweep_end = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = (sweeps != '0) ? S_LOAD : S_DONE;
            end
         end
         S_LOAD: begin
            w_next = abort ? S_IDLE : S_UP;
         end
         S_UP: begin
            if (abort)
               w_next = S_IDLE;
            else if (tercnt_in)
               w_next = S_DOWN;
         end
         S_DOWN: begin
            if (abort) begin
               w_next = S_IDLE;
            end else if (tercnt_in) begin
               w_sweep_end = 1'b1;
               w_next      = (r_rem == sweeps_w'(1)) ? S_DONE : S_UP;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data      <= '0;
         r_rem       <= '0;
         r_sweep_cnt <= '0;
      end else if (w_accept) begin
         r_sweep_cnt <= '0;
         if (sweeps != '0) begin
            r_data <= start_val;
            r_rem  <= sweeps;
         end
      end else if (w_sweep_end) begin
         r_sweep_cnt <= r_sweep_cnt + sweeps_w'(1);
         r_rem       <= r_rem - sweeps_w'(1);
      end
   end

   // terminal hold: cen drops while tercnt is high so the count never wraps
   assign ctr_cen   = ((r_state == S_UP) || (r_state == S_DOWN))
                      && !tercnt_in;
   assign ctr_load  = (r_state != S_LOAD);
   assign ctr_up_dn = (r_state != S_DOWN);
   assign busy      = (r_state == S_LOAD) || (r_state == S_UP)
                      || (r_state == S_DOWN);
   assign done      = (r_state == S_DONE);
   assign ctr_data  = r_data;
   assign sweep_cnt = r_sweep_cnt;

endmodule
